word_pack: RTL and testbench

WORD_PACK -- requirements
Module: word_pack

---
 rtl/word_pack_pkg.sv | 26 ++
 rtl/word_pack_if.sv | 31 +++
 rtl/word_pack_acc.sv | 40 ++++
 rtl/word_pack.sv | 118 +++++++++++
 tb/tb_word_pack.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/word_pack_pkg.sv
// word_pack_pkg: default widths, FSM state encoding and the lane keep-mask helper
// shared by the word_pack slice.
package word_pack_pkg;

  localparam int IN_W_DEF  = 8;
  localparam int RATIO_DEF = 4;
  localparam int KEEP_MAX  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Low `lanes` bits set, LSB-first; callers narrow the result to their lane count.
  function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned lanes);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      m[i] = (i < lanes);
    end
    return m;
  endfunction

endpackage

// File: rtl/word_pack_if.sv
// word_pack_if: block handshake, narrow input stream and wide output stream of word_pack.
// slave is the packer's view, master is the LOAD/WRITE/controller side.
interface word_pack_if import word_pack_pkg::*; #(
  parameter int IN_W  = IN_W_DEF,
  parameter int RATIO = RATIO_DEF
) ();

  logic                    ap_start;
  logic                    ap_done;
  logic                    ap_idle;
  logic                    ap_ready;
  logic [15:0]             len;
  logic [IN_W-1:0]         in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_W*RATIO-1:0]   out_data;
  logic [RATIO-1:0]        out_keep;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  ap_start, len, in_data, in_valid, out_ready,
    output ap_done, ap_idle, ap_ready, in_ready, out_data, out_keep, out_valid
  );

  modport master (
    output ap_start, len, in_data, in_valid, out_ready,
    input  ap_done, ap_idle, ap_ready, in_ready, out_data, out_keep, out_valid
  );

endinterface

// File: rtl/word_pack_acc.sv
// word_pack_acc: lane register and lane count; narrow words fill the wide word
// little-endian, lane 0 first.
module word_pack_acc import word_pack_pkg::*; #(
  parameter int IN_W  = IN_W_DEF,
  parameter int RATIO = RATIO_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [IN_W-1:0]            din,
  output logic [IN_W*RATIO-1:0]      acc_p0,
  output logic [IN_W*RATIO-1:0]      acc_nxt,
  output logic [$clog2(RATIO)-1:0]   lane_cnt
);

  int unsigned lane_base;

  assign lane_base = 32'(lane_cnt) * IN_W;

  // The first lane of a group starts from zero so unfilled lanes of a partial word read as 0.
  always_comb begin
    acc_nxt = (lane_cnt == '0) ? '0 : acc_p0;
    acc_nxt[lane_base +: IN_W] = din;
  end

  // p0: lane register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_p0   <= '0;
      lane_cnt <= '0;
    end else if (clr) begin
      lane_cnt <= '0;
    end else if (push) begin
      acc_p0   <= acc_nxt;
      lane_cnt <= lane_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/word_pack.sv
// word_pack: packs RATIO narrow words into one wide word with a block-level handshake.
// Define WORD_PACK_BEAT_CNT_EN to add the saturating beat_cnt output.
module word_pack import word_pack_pkg::*; #(
  parameter int IN_W  = IN_W_DEF,
  parameter int RATIO = RATIO_DEF
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
`ifdef WORD_PACK_BEAT_CNT_EN
  output logic [31:0] beat_cnt,
  word_pack_if.slave  bus
`else
  word_pack_if.slave  bus
`endif
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int LW    = $clog2(RATIO);

  state_t           state, state_nxt;
  logic [15:0]      rem_cnt;
  logic [OUT_W-1:0] acc_p0, acc_nxt, data_p1;
  logic [RATIO-1:0] keep_p1;
  logic             vld_p1;
  logic [LW-1:0]    lane_cnt;
  logic             start_acc, push, slot_free, take;
  logic             group_full, load_full, load_flush, acc_clr;

  assign slot_free  = !vld_p1 || bus.out_ready;
  assign take       = vld_p1 && bus.out_ready;
  assign bus.in_ready = (state == ST_PACK) && slot_free;
  assign push       = bus.in_valid && bus.in_ready;
  assign start_acc  = (state == ST_IDLE) && bus.ap_start;
  assign group_full = (lane_cnt == LW'(RATIO - 1));
  assign load_full  = push && group_full;
  assign load_flush = (state == ST_FLUSH) && slot_free;
  assign acc_clr    = start_acc || load_flush;

  word_pack_acc #(
    .IN_W  (IN_W),
    .RATIO (RATIO)
  ) u_acc (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .clr      (acc_clr),
    .push     (push),
    .din      (bus.in_data),
    .acc_p0   (acc_p0),
    .acc_nxt  (acc_nxt),
    .lane_cnt (lane_cnt)
  );

  always_comb begin
    state_nxt    = state;
    bus.ap_idle  = 1'b0;
    bus.ap_done  = 1'b0;
    bus.ap_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.ap_idle = 1'b1;
        if (bus.ap_start) state_nxt = (bus.len == 16'd0) ? ST_DONE : ST_PACK;
      end
      ST_PACK: begin
        if (push && rem_cnt == 16'd1) state_nxt = group_full ? ST_DONE : ST_FLUSH;
      end
      ST_FLUSH: begin
        if (slot_free) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // Completion waits until the last wide word has left the output register.
        if (!vld_p1) begin
          bus.ap_done  = 1'b1;
          bus.ap_ready = 1'b1;
          state_nxt    = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // p1: control state and wide output register
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state   <= ST_IDLE;
      rem_cnt <= '0;
      data_p1 <= '0;
      keep_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) rem_cnt <= bus.len;
      else if (push && rem_cnt != 16'd0) rem_cnt <= rem_cnt - 16'd1;
      if (load_full) begin
        data_p1 <= acc_nxt;
        keep_p1 <= '1;
        vld_p1  <= 1'b1;
      end else if (load_flush) begin
        data_p1 <= acc_p0;
        keep_p1 <= RATIO'(keep_mask(32'(lane_cnt)));
        vld_p1  <= 1'b1;
      end else if (take) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_p1;
  assign bus.out_keep  = keep_p1;
  assign bus.out_valid = vld_p1;

`ifdef WORD_PACK_BEAT_CNT_EN
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) beat_cnt <= '0;
    else if (take && beat_cnt != '1) beat_cnt <= beat_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_word_pack.sv
// tb_word_pack: directed vectors for word_pack with IN_W=8, RATIO=4; beat_cnt is
// checked when WORD_PACK_BEAT_CNT_EN is defined.
module tb_word_pack;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;

  always #5 ap_clk = ~ap_clk;

  word_pack_if #(.IN_W(8), .RATIO(4)) bus ();

`ifdef WORD_PACK_BEAT_CNT_EN
  logic [31:0] beat_cnt;
`endif

  word_pack #(.IN_W(8), .RATIO(4)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
`ifdef WORD_PACK_BEAT_CNT_EN
    .beat_cnt (beat_cnt),
`endif
    .bus      (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  src    [16];
  logic [31:0] got_d  [8];
  logic [3:0]  got_k  [8];
  logic        inr_log[64];
  logic        ov_log [64];
  logic [31:0] od_log [64];
  int          n_got, done_at, done_cnt, sent;

  // Runs one job of n words; out_ready is low for cycles [stall_lo, stall_hi);
  // a stray ap_start (len=2) is raised at cycle poke_at. Cycle 0 is the first cycle after start.
  task automatic pump(input int n, input int stall_lo, input int stall_hi, input int poke_at);
    bit fin;
    fin = 1'b0;
    n_got = 0; done_at = -1; done_cnt = 0; sent = 0;
    @(negedge ap_clk);
    bus.len = 16'(n);
    bus.ap_start = 1'b1;
    for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
      @(negedge ap_clk);
      bus.ap_start  = (cyc == poke_at);
      if (cyc == poke_at) bus.len = 16'd2;
      bus.out_ready = !(cyc >= stall_lo && cyc < stall_hi);
      bus.in_valid  = (sent < n);
      bus.in_data   = (sent < n) ? src[sent] : 8'h00;
      #1;
      inr_log[cyc] = bus.in_ready;
      ov_log[cyc]  = bus.out_valid;
      od_log[cyc]  = bus.out_data;
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready && n_got < 8) begin
        got_d[n_got] = bus.out_data;
        got_k[n_got] = bus.out_keep;
        n_got++;
      end
      if (bus.ap_done) begin
        done_cnt++;
        done_at = cyc;
        fin = 1'b1;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    bus.ap_start = 1'b0; bus.len = 16'd0; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'hEE;
    ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    #1;
    tests_run++; if (bus.ap_idle !== 1'b1) begin tests_failed++; $display("FAIL reset_idle got=%b want=1", bus.ap_idle); end
    tests_run++; if (bus.ap_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b want=0", bus.ap_done); end
    tests_run++; if (bus.ap_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got=%b want=0", bus.ap_ready); end
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    tests_run++; if (bus.out_keep !== 4'h0) begin tests_failed++; $display("FAIL reset_out_keep got=%h want=0", bus.out_keep); end
    tests_run++; if (bus.out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data got=%h want=0", bus.out_data); end
`ifdef WORD_PACK_BEAT_CNT_EN
    tests_run++; if (beat_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_beat_cnt got=%0d want=0", beat_cnt); end
`else
    tests_run++; if (bus.ap_idle !== 1'b1) begin tests_failed++; $display("FAIL reset_idle_hold got=%b want=1", bus.ap_idle); end
`endif
    ap_rst_n = 1'b1;
    @(negedge ap_clk); #1;
    tests_run++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL idle_ignores_in got=%b%b want=00", bus.out_valid, bus.in_ready); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_full_groups();
    int stalls;
    for (int i = 0; i < 8; i++) src[i] = 8'(i + 1);
    pump(8, 99, 99, 2);
    stalls = 0;
    for (int c = 0; c < 8; c++) if (inr_log[c] !== 1'b1) stalls++;
    tests_run++; if (n_got !== 2) begin tests_failed++; $display("FAIL full_beats got=%0d want=2", n_got); end
    tests_run++; if (got_d[0] !== 32'h04030201) begin tests_failed++; $display("FAIL full_word0 got=%h want=04030201", got_d[0]); end
    tests_run++; if (got_k[0] !== 4'hF) begin tests_failed++; $display("FAIL full_keep0 got=%h want=f", got_k[0]); end
    tests_run++; if (got_d[1] !== 32'h08070605) begin tests_failed++; $display("FAIL full_word1 got=%h want=08070605", got_d[1]); end
    tests_run++; if (got_k[1] !== 4'hF) begin tests_failed++; $display("FAIL full_keep1 got=%h want=f", got_k[1]); end
    tests_run++; if (ov_log[3] !== 1'b0 || ov_log[4] !== 1'b1) begin tests_failed++; $display("FAIL full_latency got=%b%b want=01", ov_log[3], ov_log[4]); end
    tests_run++; if (stalls !== 0) begin tests_failed++; $display("FAIL full_throughput stalls=%0d want=0", stalls); end
    tests_run++; if (done_cnt !== 1 || done_at !== 9) begin tests_failed++; $display("FAIL full_done cnt=%0d at=%0d want=1 at 9", done_cnt, done_at); end
    @(negedge ap_clk); #1;
    tests_run++; if (bus.ap_done !== 1'b0 || bus.ap_idle !== 1'b1) begin tests_failed++; $display("FAIL full_after done=%b idle=%b want=0 1", bus.ap_done, bus.ap_idle); end
  endtask

  task automatic test_partial();
    for (int i = 0; i < 6; i++) src[i] = 8'hA0 + 8'(i);
    pump(6, 99, 99, -1);
    tests_run++; if (n_got !== 2) begin tests_failed++; $display("FAIL part_beats got=%0d want=2", n_got); end
    tests_run++; if (got_d[0] !== 32'hA3A2A1A0 || got_k[0] !== 4'hF) begin tests_failed++; $display("FAIL part_word0 got=%h/%h want=a3a2a1a0/f", got_d[0], got_k[0]); end
    tests_run++; if (got_d[1] !== 32'h0000A5A4) begin tests_failed++; $display("FAIL part_word1 got=%h want=0000a5a4", got_d[1]); end
    tests_run++; if (got_k[1] !== 4'h3) begin tests_failed++; $display("FAIL part_keep1 got=%h want=3", got_k[1]); end
    tests_run++; if (done_cnt !== 1 || done_at !== 8) begin tests_failed++; $display("FAIL part_done cnt=%0d at=%0d want=1 at 8", done_cnt, done_at); end
  endtask

  task automatic test_len_zero();
    pump(0, 99, 99, -1);
    tests_run++; if (n_got !== 0 || ov_log[0] !== 1'b0) begin tests_failed++; $display("FAIL zero_beats got=%0d want=0", n_got); end
    tests_run++; if (done_cnt !== 1 || done_at !== 0) begin tests_failed++; $display("FAIL zero_done cnt=%0d at=%0d want=1 at 0", done_cnt, done_at); end
    @(negedge ap_clk); #1;
    tests_run++; if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0) begin tests_failed++; $display("FAIL zero_idle idle=%b done=%b want=1 0", bus.ap_idle, bus.ap_done); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) src[i] = 8'h11 + 8'(i);
    pump(8, 4, 9, -1);
    for (int c = 4; c < 9; c++) begin
      tests_run++; if (inr_log[c] !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready c%0d got=%b want=0", c, inr_log[c]); end
      tests_run++; if (ov_log[c] !== 1'b1) begin tests_failed++; $display("FAIL bp_out_valid c%0d got=%b want=1", c, ov_log[c]); end
      tests_run++; if (od_log[c] !== 32'h14131211) begin tests_failed++; $display("FAIL bp_hold c%0d got=%h want=14131211", c, od_log[c]); end
    end
    tests_run++; if (n_got !== 2) begin tests_failed++; $display("FAIL bp_beats got=%0d want=2", n_got); end
    tests_run++; if (got_d[0] !== 32'h14131211 || got_d[1] !== 32'h18171615) begin tests_failed++; $display("FAIL bp_words got=%h,%h want=14131211,18171615", got_d[0], got_d[1]); end
    tests_run++; if (done_cnt !== 1 || done_at !== 14) begin tests_failed++; $display("FAIL bp_done cnt=%0d at=%0d want=1 at 14", done_cnt, done_at); end
  endtask

  task automatic test_reset_midrun();
    int ov_seen;
    for (int i = 0; i < 8; i++) src[i] = 8'h20 + 8'(i);
    @(negedge ap_clk);
    bus.len = 16'd8; bus.ap_start = 1'b1;
    sent = 0;
    for (int cyc = 0; cyc < 20 && sent < 3; cyc++) begin
      @(negedge ap_clk);
      bus.ap_start = 1'b0; bus.in_valid = 1'b1; bus.in_data = src[sent];
      #1;
      if (bus.in_ready) sent++;
    end
    @(negedge ap_clk);
    bus.in_valid = 1'b0; ap_rst_n = 1'b0;
    @(negedge ap_clk); #1;
    tests_run++; if (sent !== 3) begin tests_failed++; $display("FAIL mid_sent got=%0d want=3", sent); end
    tests_run++; if (bus.ap_idle !== 1'b1 || bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_state idle=%b in_ready=%b want=1 0", bus.ap_idle, bus.in_ready); end
    tests_run++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin tests_failed++; $display("FAIL mid_out valid=%b data=%h want=0 0", bus.out_valid, bus.out_data); end
    ap_rst_n = 1'b1;
    ov_seen = 0;
    bus.in_valid = 1'b1; bus.in_data = 8'h99;
    for (int c = 0; c < 4; c++) begin
      @(negedge ap_clk); #1;
      if (bus.out_valid !== 1'b0) ov_seen++;
    end
    bus.in_valid = 1'b0;
    tests_run++; if (ov_seen !== 0) begin tests_failed++; $display("FAIL mid_no_beat got=%0d want=0", ov_seen); end
    for (int i = 0; i < 4; i++) src[i] = 8'h31 + 8'(i);
    pump(4, 99, 99, -1);
    tests_run++; if (n_got !== 1) begin tests_failed++; $display("FAIL mid_rerun_beats got=%0d want=1", n_got); end
    tests_run++; if (got_d[0] !== 32'h34333231 || got_k[0] !== 4'hF) begin tests_failed++; $display("FAIL mid_rerun_word got=%h/%h want=34333231/f", got_d[0], got_k[0]); end
    tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL mid_rerun_done got=%0d want=1", done_cnt); end
`ifdef WORD_PACK_BEAT_CNT_EN
    tests_run++; if (beat_cnt !== 32'd1) begin tests_failed++; $display("FAIL mid_beat_cnt got=%0d want=1", beat_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_groups();
    test_partial();
    test_len_zero();
    test_backpressure();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
